// File: rtl/watch_pkg.sv
// Shared constants for the watch timebase: run-state encoding, reset divisor, decade terminals.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // 50 MHz / 50_000 = 1 kHz prescale period
  localparam int unsigned DIV_DEFAULT_VAL = 50_000;
  // Divisors below this cannot produce a distinct strobe cycle
  localparam int unsigned DIV_MIN         = 2;
  localparam int unsigned DEC_A_TERM      = 9;
  localparam int unsigned DEC_B_TERM      = 99;

endpackage

// File: rtl/tick_sched_ctrl_if.sv
// Command, divisor-config and tick bundle between the watch controller and its users.
// Latency: n/a (wiring only).
// Backpressure: cfg_valid/cfg_ready handshake; commands and ticks are single-cycle strobes.
// Ports: start/pause/clear commands, cfg_valid/cfg_div/cfg_ready divisor offer,
//        tick_1k/tick_100/tick_1 strobes, 2-bit run state.
interface tick_sched_ctrl_if #(
  parameter int DIV_W = 32
);
  logic             start;
  logic             pause;
  logic             clear;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             tick_1k;
  logic             tick_100;
  logic             tick_1;
  logic [1:0]       state;

  modport master (
    output start, pause, clear, cfg_valid, cfg_div,
    input  cfg_ready, tick_1k, tick_100, tick_1, state
  );

  modport slave (
    input  start, pause, clear, cfg_valid, cfg_div,
    output cfg_ready, tick_1k, tick_100, tick_1, state
  );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo counter 0..term with enable, synchronous clear and async reset; wrap flags the terminal step.
// Latency: count updates on the enabled edge; wrap is combinational from count/en/clr.
// Backpressure: none; en simply holds the count.
// Ports: clk, rst, en, clr, term (terminal value), count, wrap.
module mod_n_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         wrap
);

  // >= rather than == so a count left above a newly shortened terminal
  // (divisor changed while paused) returns to zero instead of running away.
  assign wrap = en && !clr && (count >= term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/tick_sched_ctrl.sv
// Watch timebase run control: IDLE/RUN/PAUSE sequencing, prescaler and 1k/100/1 Hz strobes.
// Latency: strobes and state registered, one cycle after the wrap/command edge.
// Backpressure: cfg_ready low while a divisor is shadowed; it drains at the next period boundary.
// Ports: CLOCK, RESET (async, active-high), bus (tick_sched_ctrl_if.slave).
module tick_sched_ctrl
  import watch_pkg::*;
#(
  parameter int          DIV_W       = 32,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_VAL
) (
  input  logic             CLOCK,
  input  logic             RESET,
  tick_sched_ctrl_if.slave bus
);

  state_e           st_q, st_d;
  logic             cnt_en, cnt_clr;
  logic [DIV_W-1:0] div_act, shadow_div, pre_cnt, cfg_clamped;
  logic             pend;
  logic             pre_wrap, a_wrap, b_wrap;
  logic [3:0]       a_cnt;
  logic [6:0]       b_cnt;
  logic             tick_1k_q, tick_100_q, tick_1_q;

  // Highest-priority asserted command is the only one acted on; a lower one
  // in the same cycle is dropped even if the higher one is a no-op.
  always_comb begin
    st_d    = st_q;
    cnt_en  = 1'b0;
    cnt_clr = bus.clear;
    case (st_q)
      ST_IDLE: begin
        if (!bus.clear && !bus.pause && bus.start) st_d = ST_RUN;
      end
      ST_RUN: begin
        // A pause sampled on this edge also freezes the counters on this edge.
        cnt_en = !bus.clear && !bus.pause;
        if (bus.clear)      st_d = ST_IDLE;
        else if (bus.pause) st_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.clear)                       st_d = ST_IDLE;
        else if (!bus.pause && bus.start)    st_d = ST_RUN;
      end
      default: begin
        st_d    = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  mod_n_counter #(.W(DIV_W)) u_pre (
    .clk(CLOCK), .rst(RESET), .en(cnt_en), .clr(cnt_clr),
    .term(div_act - DIV_W'(1)), .count(pre_cnt), .wrap(pre_wrap)
  );

  mod_n_counter #(.W(4)) u_dec_a (
    .clk(CLOCK), .rst(RESET), .en(pre_wrap), .clr(cnt_clr),
    .term(4'(DEC_A_TERM)), .count(a_cnt), .wrap(a_wrap)
  );

  mod_n_counter #(.W(7)) u_dec_b (
    .clk(CLOCK), .rst(RESET), .en(a_wrap), .clr(cnt_clr),
    .term(7'(DEC_B_TERM)), .count(b_cnt), .wrap(b_wrap)
  );

  assign cfg_clamped = (bus.cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : bus.cfg_div;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      st_q       <= ST_IDLE;
      tick_1k_q  <= 1'b0;
      tick_100_q <= 1'b0;
      tick_1_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      tick_1k_q  <= pre_wrap;
      tick_100_q <= a_wrap;
      tick_1_q   <= b_wrap;
    end
  end

  // Shadow drains when the period in progress ends (RUN), immediately when not
  // running, or on clear. The old divisor still governs the wrap on that edge.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      div_act    <= DIV_W'(DIV_DEFAULT);
      shadow_div <= '0;
      pend       <= 1'b0;
    end else if (pend) begin
      if (bus.clear || st_q != ST_RUN || pre_wrap) begin
        div_act <= shadow_div;
        pend    <= 1'b0;
      end
    end else if (bus.cfg_valid) begin
      shadow_div <= cfg_clamped;
      pend       <= 1'b1;
    end
  end

  assign bus.state     = st_q;
  assign bus.cfg_ready = !pend;
  assign bus.tick_1k   = tick_1k_q;
  assign bus.tick_100  = tick_100_q;
  assign bus.tick_1    = tick_1_q;

  // IDLE is only entered through a counter clear and nothing counts while idle.
  a_idle_zero : assert property (@(posedge CLOCK) disable iff (RESET)
    (st_q == ST_IDLE) |-> (pre_cnt == '0 && a_cnt == '0 && b_cnt == '0));

endmodule

// File: tb/tb_tick_sched_ctrl.sv
module tb_tick_sched_ctrl;

  typedef struct packed {
    logic [1:0] st;
    logic       rdy;
    logic       t1k;
    logic       t100;
    logic       t1;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  tick_sched_ctrl_if #(.DIV_W(32)) bus ();

  tick_sched_ctrl #(.DIV_W(32), .DIV_DEFAULT(4)) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int n_t1k, n_t100, n_t1;

  obs_t exp_q[$];

  // Reference model: spec-level state (0 idle, 1 run, 2 pause), counters as integers.
  int m_st, m_pre, m_a, m_b, m_div, m_shadow;
  bit m_pend, m_last_t1k;

  task automatic model_reset();
    m_st = 0; m_pre = 0; m_a = 0; m_b = 0;
    m_div = 4; m_shadow = 0; m_pend = 0; m_last_t1k = 0;
  endtask

  task automatic model_edge(input bit s, p, c, v, input int unsigned d);
    bit   running, wrap;
    obs_t e;
    running = (m_st == 1) && !c && !p;
    wrap    = running && (m_pre + 1 >= m_div);
    e.t1k   = wrap;
    e.t100  = wrap && (m_a == 9);
    e.t1    = wrap && (m_a == 9) && (m_b == 99);
    if (m_pend) begin
      if (c || m_st != 1 || wrap) begin
        m_div  = m_shadow;
        m_pend = 0;
      end
    end else if (v) begin
      m_shadow = (d < 2) ? 2 : int'(d);
      m_pend   = 1;
    end
    if (c) begin
      m_pre = 0; m_a = 0; m_b = 0;
    end else if (running) begin
      if (wrap) begin
        m_pre = 0;
        if (m_a == 9) begin
          m_a = 0;
          m_b = (m_b + 1) % 100;
        end else begin
          m_a = m_a + 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (c)                   m_st = 0;
    else if (p) begin
      if (m_st == 1)         m_st = 2;
    end else if (s) begin
      if (m_st != 1)         m_st = 1;
    end
    e.st  = 2'(m_st);
    e.rdy = !m_pend;
    m_last_t1k = wrap;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; called between edges, returns 1 time unit after the edge.
  task automatic step(input bit s, p, c, v, input int unsigned d);
    bus.start = s; bus.pause = p; bus.clear = c; bus.cfg_valid = v; bus.cfg_div = d;
    @(posedge clk);
    model_edge(s, p, c, v, d);
    #1;
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.cfg_valid = 0; bus.cfg_div = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic settle_and_zero();
    n_t1k = 0; n_t100 = 0; n_t1 = 0;
  endtask

  // Monitor: every clock the DUT presents its registered outputs; compare against queue.
  always @(negedge clk) begin
    obs_t e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bus.state, bus.cfg_ready, bus.tick_1k, bus.tick_100, bus.tick_1};
      n_checks++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t: got st=%0d rdy=%0b ticks=%b%b%b expected st=%0d rdy=%0b ticks=%b%b%b",
                 $time, g.st, g.rdy, g.t1k, g.t100, g.t1, e.st, e.rdy, e.t1k, e.t100, e.t1);
      end
      if (bus.tick_1k)  n_t1k++;
      if (bus.tick_100) n_t100++;
      if (bus.tick_1)   n_t1++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.cfg_valid = 0; bus.cfg_div = 0;
    model_reset();
    #5;
    chk("reset_state", bus.state, 0);
    chk("reset_cfg_ready", bus.cfg_ready, 1);
    chk("reset_ticks", {bus.tick_1k, bus.tick_100, bus.tick_1}, 0);
    @(negedge clk);
    rst = 0;

    // Default divisor 4: full 1 s cycle of the decades
    settle_and_zero();
    step(1, 0, 0, 0, 0);
    idle(4010);
    @(negedge clk); #1;
    chk("div4_tick_1k_count", n_t1k, 1002);
    chk("div4_tick_100_count", n_t100, 100);
    chk("div4_tick_1_count", n_t1, 1);

    // Divisor 10 with a pause interval
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 10);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(23);
    step(0, 1, 0, 0, 0);
    settle_and_zero();
    idle(49);
    @(negedge clk); #1;
    chk("pause_no_ticks", n_t1k, 0);
    step(1, 0, 0, 0, 0);
    idle(12);

    // start+pause+clear together in RUN
    idle(3);
    step(1, 1, 1, 0, 0);
    chk("clr_pre", dut.pre_cnt, 0);
    chk("clr_dec_a", dut.a_cnt, 0);
    chk("clr_dec_b", dut.b_cnt, 0);
    idle(5);

    // Divisor 8 then 3 offered mid-period
    step(0, 0, 0, 1, 8);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(11);
    step(0, 0, 0, 1, 3);
    chk("cfg_ready_pending", bus.cfg_ready, 0);
    idle(20);

    // Divisor 0 clamps to 2
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    settle_and_zero();
    idle(10);
    @(negedge clk); #1;
    chk("clamp2_tick_count", n_t1k, 5);

    // Randomized commands and config offers
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 12));
    end

    // Async reset mid-period with a pending divisor
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 6);
    idle(1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && !m_last_t1k; i++) step(0, 0, 0, 0, 0);
    chk("wait_first_tick", m_last_t1k, 1);
    step(0, 0, 0, 1, 9);
    idle(1);
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("arst_state", bus.state, 0);
    chk("arst_cfg_ready", bus.cfg_ready, 1);
    chk("arst_ticks", {bus.tick_1k, bus.tick_100, bus.tick_1}, 0);
    chk("arst_div_act", dut.div_act, 4);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    exp_q.delete();
    step(1, 0, 0, 0, 0);
    idle(12);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tick_sched_ctrl.md
# tick_sched_ctrl

Run-control and scheduling block for the watch timebase. It owns the programmable prescaler from the 50 MHz board clock and sequences it through idle/run/pause states. It emits single-cycle enable strobes at 1 kHz, 100 Hz and 1 Hz for the stopwatch, time-keeping and display-scan logic, and accepts a new prescale divisor through a valid/ready handshake that takes effect only on a period boundary.

## Interface
- DIV_W, 32, width of the divisor and prescale counter
- DIV_DEFAULT, 50_000, divisor loaded at reset (50 MHz / 50_000 = 1 kHz)
- CLOCK  in  1  system clock (50 MHz); all logic on its rising edge
- RESET  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request: enter RUN
- pause  in  1  single-cycle request: freeze counters
- clear  in  1  single-cycle request: zero all counters, return to IDLE
- cfg_valid  in  1  new divisor offered
- cfg_div  in  DIV_W  offered divisor, in CLOCK cycles per 1 kHz tick
- cfg_ready  out  1  high when the shadow register is empty and can accept
- tick_1k  out  1  one-cycle strobe per prescale period
- tick_100  out  1  one-cycle strobe every 10th tick_1k
- tick_1  out  1  one-cycle strobe every 100th tick_100
- state  out  2  IDLE=0, RUN=1, PAUSE=2 (3 unused)

## Operation
- **States**
  - IDLE: counters at 0, no ticks.
  - RUN: prescaler advances every cycle.
  - PAUSE: all counters hold, no ticks.
- **Command priority** (same cycle): clear > pause > start.
  - clear, from any state: go to IDLE and zero the prescaler and both decade counters.
  - pause: RUN -> PAUSE; ignored in IDLE and PAUSE.
  - start: IDLE or PAUSE -> RUN; ignored in RUN.
  - Unused state code 3 returns to IDLE on the next edge.
- **Prescaler** (pre, DIV_W bits): counts 0..div_act-1 while RUN. At div_act-1 it wraps to 0 and asserts tick_1k on the next cycle.
- **Decade A** (0..9): advances on each wrap. tick_100 is asserted with the tick_1k that moves it from 9 to 0.
- **Decade B** (0..99): advances on each tick_100. tick_1 is asserted with the tick_100 that moves it from 99 to 0.
- All three strobes are coincident on the cycle where all three wrap together.
- **Divisor handshake**
  - A transfer occurs when cfg_valid && cfg_ready. cfg_div is captured into the shadow register and cfg_ready drops.
  - Values below 2 are clamped to 2.
  - If state != RUN, div_act takes the shadow value on the next edge and cfg_ready rises one cycle after the transfer.
  - If state == RUN, div_act updates on the edge where pre wraps. cfg_ready rises on that same edge.
  - The period in progress always completes with the old divisor.
  - A clear while a transfer is pending applies the shadow value immediately.
- **Reset** values:
  - state=IDLE; pre=0; both decade counters 0.
  - div_act=DIV_DEFAULT; shadow empty; cfg_ready=1.
  - tick_1k, tick_100, tick_1 all 0.

## Timing
- All outputs are registered. Nothing is combinational from the inputs to the outputs.
- start sampled at edge t:
  - state=RUN visible after t.
  - pre counts from 0 on edge t+1.
  - First tick_1k is high for the cycle after edge t+div_act.
- Tick spacing is exactly div_act cycles. A PAUSE interval inserts no extra count and loses none.
- pause sampled at edge t: no tick is asserted after edge t. A wrap that would have occurred at t is held until RUN resumes.
- clear during a tick cycle: that tick completes its one cycle; counters read 0 after the clear edge.
- RESET asserted mid-operation forces all reset values immediately, regardless of CLOCK.

## Structure
- Shared package `watch_pkg`:
  - state encoding constants (IDLE/RUN/PAUSE);
  - DIV_DEFAULT;
  - decade terminal counts 9 and 99.
- One sub-module, `mod_n_counter`:
  - parameterised width and terminal value, with enable, synchronous clear and async reset;
  - outputs count and wrap flag.
  - Instantiated three times: prescaler with runtime terminal div_act-1, decade A, decade B.
- The state machine, command priority and divisor shadow/handshake logic live in the top.

## Test plan
- Reset, then start with DIV_DEFAULT overridden to 4 -> tick_1k every 4 cycles; tick_100 every 40 cycles; tick_1 every 4000 cycles, coincident with tick_1k and tick_100.
- DIV=10: start, run 23 cycles, pause for 50 cycles, start -> next tick_1k at 30 RUN cycles total, no ticks during PAUSE.
- start, pause and clear asserted in the same cycle while in RUN -> state=IDLE, all counters 0, no ticks.
- DIV=8 in RUN, offer cfg_div=3 mid-period -> cfg_ready low until wrap; remaining ticks spaced 8 then 3; cfg_ready high on the wrap edge.
- cfg_div=0 while IDLE, then start -> clamped to 2; tick_1k every 2 cycles.
- Assert RESET asynchronously mid-period with pending config -> outputs immediately 0, state=IDLE, cfg_ready=1, divisor back to DIV_DEFAULT.
